// File: rtl/memory_pkg.sv
// memory_pkg: shared types for the memory-stage access controller.
// Load/store op codes, bus access sizes, controller states.
package memory_pkg;

  typedef enum logic [3:0] {
    OP_NONE = 4'd0,
    OP_LB   = 4'd1,
    OP_LBU  = 4'd2,
    OP_LH   = 4'd3,
    OP_LHU  = 4'd4,
    OP_LW   = 4'd5,
    OP_SB   = 4'd6,
    OP_SH   = 4'd7,
    OP_SW   = 4'd8
  } mem_op_t;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2
  } msize_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_RESP,
    ST_DONE
  } mem_ctrl_state_t;

  function automatic msize_t op_size(mem_op_t op);
    msize_t s;
    case (op)
      OP_LB, OP_LBU, OP_SB: s = SZ_BYTE;
      OP_LH, OP_LHU, OP_SH: s = SZ_HALF;
      default:              s = SZ_WORD;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/mem_align.sv
// mem_align: store lane steering, load select/extend, misalign detect.
// Ports: op/off/wdata/raw in, size/strobe/wdata/load out; chk_* -> misalign.
module mem_align
  import memory_pkg::*;
(
  input  mem_op_t     op_i,
  input  logic [1:0]  off_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] raw_i,
  input  mem_op_t     chk_op_i,
  input  logic [1:0]  chk_off_i,
  output msize_t      size_o,
  output logic [3:0]  strobe_o,
  output logic [31:0] wdata_o,
  output logic [31:0] load_o,
  output logic        misalign_o
);

  logic [7:0]  lb;
  logic [15:0] lh;

  assign size_o = op_size(op_i);
  assign lb = raw_i[{off_i, 3'b000} +: 8];
  assign lh = raw_i[{off_i[1], 4'b0000} +: 16];

  always_comb begin
    strobe_o = 4'b0000;
    wdata_o  = wdata_i;
    case (op_i)
      OP_SB: begin
        strobe_o = 4'b0001 << off_i;
        wdata_o  = {4{wdata_i[7:0]}};
      end
      OP_SH: begin
        strobe_o = 4'b0011 << off_i;
        wdata_o  = {2{wdata_i[15:0]}};
      end
      OP_SW:   strobe_o = 4'b1111;
      default: strobe_o = 4'b0000;
    endcase
  end

  always_comb begin
    load_o = '0;
    case (op_i)
      OP_LB:   load_o = {{24{lb[7]}}, lb};
      OP_LBU:  load_o = {24'b0, lb};
      OP_LH:   load_o = {{16{lh[15]}}, lh};
      OP_LHU:  load_o = {16'b0, lh};
      OP_LW:   load_o = raw_i;
      default: load_o = '0;
    endcase
  end

  always_comb begin
    misalign_o = 1'b0;
    case (chk_op_i)
      OP_LH, OP_LHU, OP_SH: misalign_o = chk_off_i[0];
      OP_LW, OP_SW:         misalign_o = |chk_off_i;
      default:              misalign_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: memory-stage load/store sequencer onto the data bus.
// in_* from stage reg, dreq_*/dresp_* bus, mem_stall/done/rdata/misalign out.
module mem_access_ctrl
  import memory_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  input  mem_op_t     in_op,
  input  logic [31:0] in_addr,
  input  logic [31:0] in_wdata,
  input  logic        flush,
  input  logic        downstream_stall,
  output logic        dreq_valid,
  output logic [31:0] dreq_addr,
  output msize_t      dreq_size,
  output logic [3:0]  dreq_strobe,
  output logic [31:0] dreq_data,
  input  logic        dresp_addr_ok,
  input  logic        dresp_data_ok,
  input  logic [31:0] dresp_data,
  output logic        mem_stall,
  output logic        done,
  output logic [31:0] rdata,
  output logic        misalign
);

  mem_ctrl_state_t state_q;
  mem_op_t         op_q;
  logic [31:0]     addr_q;
  logic [31:0]     wdata_q;
  logic [31:0]     rdata_q;
  logic            done_q;
  logic            squash_q;

  logic            chk_mis;
  logic            accept;
  logic            kill;
  logic [3:0]      strobe;
  logic [31:0]     ldata;

  // Request side works only from latched fields; the check port
  // looks at the live stage register for misalign.
  mem_align u_align (
    .op_i       (op_q),
    .off_i      (addr_q[1:0]),
    .wdata_i    (wdata_q),
    .raw_i      (dresp_data),
    .chk_op_i   (in_op),
    .chk_off_i  (in_addr[1:0]),
    .size_o     (dreq_size),
    .strobe_o   (strobe),
    .wdata_o    (dreq_data),
    .load_o     (ldata),
    .misalign_o (chk_mis)
  );

  assign misalign = in_valid & chk_mis;
  assign accept   = (state_q == ST_IDLE) & in_valid &
                    (in_op != OP_NONE) & ~chk_mis & ~flush;
  // A squash raised this cycle counts as well as an earlier one.
  assign kill     = squash_q | flush;

  assign dreq_valid  = (state_q == ST_REQ);
  assign dreq_addr   = addr_q;
  assign dreq_strobe = dreq_valid ? strobe : 4'b0000;
  assign mem_stall   = accept | (state_q == ST_REQ) |
                       (state_q == ST_RESP);
  assign done        = done_q & ~flush;
  assign rdata       = rdata_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      op_q     <= OP_NONE;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      done_q   <= 1'b0;
      squash_q <= 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (accept) begin
            op_q     <= in_op;
            addr_q   <= in_addr;
            wdata_q  <= in_wdata;
            squash_q <= 1'b0;
            state_q  <= ST_REQ;
          end
        end
        ST_REQ: begin
          if (flush) squash_q <= 1'b1;
          if (dresp_addr_ok) begin
            if (dresp_data_ok) begin
              if (kill) begin
                squash_q <= 1'b0;
                state_q  <= ST_IDLE;
              end else begin
                rdata_q <= ldata;
                done_q  <= 1'b1;
                state_q <= ST_DONE;
              end
            end else begin
              state_q <= ST_RESP;
            end
          end
        end
        ST_RESP: begin
          if (flush) squash_q <= 1'b1;
          if (dresp_data_ok) begin
            if (kill) begin
              squash_q <= 1'b0;
              state_q  <= ST_IDLE;
            end else begin
              rdata_q <= ldata;
              done_q  <= 1'b1;
              state_q <= ST_DONE;
            end
          end
        end
        ST_DONE: begin
          if (flush || !downstream_stall) begin
            done_q  <= 1'b0;
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb_mem_access_ctrl: directed scoreboard bench for mem_access_ctrl.
// Stimulus queues expected bus requests and load results; monitor compares.
module tb_mem_access_ctrl;
  import memory_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  mem_op_t     in_op;
  logic [31:0] in_addr;
  logic [31:0] in_wdata;
  logic        flush;
  logic        downstream_stall;
  logic        dreq_valid;
  logic [31:0] dreq_addr;
  msize_t      dreq_size;
  logic [3:0]  dreq_strobe;
  logic [31:0] dreq_data;
  logic        dresp_addr_ok;
  logic        dresp_data_ok;
  logic [31:0] dresp_data;
  logic        mem_stall;
  logic        done;
  logic [31:0] rdata;
  logic        misalign;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] addr;
    logic [1:0]  size;
    logic [3:0]  strobe;
    logic [31:0] data;
    bit          chk_data;
  } req_t;

  typedef struct {
    bit          is_load;
    logic [31:0] val;
  } rsp_t;

  req_t req_q[$];
  rsp_t rsp_q[$];

  mem_access_ctrl dut (
    .clk              (clk),
    .reset            (reset),
    .in_valid         (in_valid),
    .in_op            (in_op),
    .in_addr          (in_addr),
    .in_wdata         (in_wdata),
    .flush            (flush),
    .downstream_stall (downstream_stall),
    .dreq_valid       (dreq_valid),
    .dreq_addr        (dreq_addr),
    .dreq_size        (dreq_size),
    .dreq_strobe      (dreq_strobe),
    .dreq_data        (dreq_data),
    .dresp_addr_ok    (dresp_addr_ok),
    .dresp_data_ok    (dresp_data_ok),
    .dresp_data       (dresp_data),
    .mem_stall        (mem_stall),
    .done             (done),
    .rdata            (rdata),
    .misalign         (misalign)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push_req(input logic [31:0] a, input logic [1:0] sz,
                          input logic [3:0] st, input logic [31:0] d,
                          input bit cd);
    req_t r;
    r.addr = a; r.size = sz; r.strobe = st; r.data = d; r.chk_data = cd;
    req_q.push_back(r);
  endtask

  task automatic push_rsp(input bit ld, input logic [31:0] v);
    rsp_t r;
    r.is_load = ld; r.val = v;
    rsp_q.push_back(r);
  endtask

  // Monitor: request fields every REQ cycle, results on done.
  bit          prev_done = 1'b0;
  bit          prev_ds = 1'b0;
  rsp_t        cur;
  always @(negedge clk) begin
    if (dreq_valid) begin
      if (req_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL req_unexpected: got addr %h expected none",
                 dreq_addr);
      end else begin
        check("req_addr", dreq_addr, req_q[0].addr);
        check("req_size", 32'(dreq_size), 32'(req_q[0].size));
        check("req_strobe", 32'(dreq_strobe), 32'(req_q[0].strobe));
        if (req_q[0].chk_data)
          check("req_data", dreq_data, req_q[0].data);
        if (dresp_addr_ok) void'(req_q.pop_front());
      end
    end
    if (done) begin
      if (!(prev_done && prev_ds)) begin
        if (rsp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL done_unexpected: got done 1 expected 0");
        end else begin
          cur = rsp_q.pop_front();
          if (cur.is_load) check("rdata", rdata, cur.val);
        end
      end else if (cur.is_load) begin
        check("rdata_held", rdata, cur.val);
      end
    end
    prev_done = done;
    prev_ds   = downstream_stall;
  end

  // One access: ad = extra REQ cycles before addr_ok; dd < 0 gives
  // data_ok with addr_ok, else dd RESP cycles precede data_ok.
  task automatic issue(input mem_op_t op, input logic [31:0] a,
                       input logic [31:0] wd, input logic [31:0] raw,
                       input int ad, input int dd, input bit fl,
                       input int ds, input int exp_stall,
                       input int exp_done);
    int stalls = 0;
    int dones = 0;
    int dsl = ds;
    in_valid = 1'b1; in_op = op; in_addr = a; in_wdata = wd;
    @(negedge clk);
    check("accept_misalign", 32'(misalign), 32'd0);
    if (mem_stall) stalls++;
    @(posedge clk); #1;
    in_addr = ~a; in_wdata = ~wd;
    for (int i = 0; i < ad; i++) begin
      @(negedge clk); if (mem_stall) stalls++;
      @(posedge clk); #1;
    end
    dresp_addr_ok = 1'b1;
    if (dd < 0) begin dresp_data_ok = 1'b1; dresp_data = raw; end
    @(negedge clk); if (mem_stall) stalls++;
    @(posedge clk); #1;
    dresp_addr_ok = 1'b0; dresp_data_ok = 1'b0;
    if (dd >= 0) begin
      if (fl) begin flush = 1'b1; in_valid = 1'b0; end
      for (int i = 0; i < dd; i++) begin
        @(negedge clk); if (mem_stall) stalls++;
        @(posedge clk); #1;
        flush = 1'b0;
      end
      dresp_data_ok = 1'b1; dresp_data = raw;
      @(negedge clk); if (mem_stall) stalls++;
      @(posedge clk); #1;
      dresp_data_ok = 1'b0;
    end
    in_valid = 1'b0; in_op = OP_NONE;
    downstream_stall = (dsl > 0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (mem_stall) stalls++;
      if (!done) break;
      dones++;
      @(posedge clk); #1;
      if (dsl > 0) dsl--;
      downstream_stall = (dsl > 0);
    end
    @(posedge clk); #1;
    downstream_stall = 1'b0;
    check("stall_cycles", stalls, exp_stall);
    check("done_cycles", dones, exp_done);
  endtask

  task automatic bad(input mem_op_t op, input logic [31:0] a);
    in_valid = 1'b1; in_op = op; in_addr = a; in_wdata = 32'h1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("bad_misalign", 32'(misalign), 32'd1);
      check("bad_stall", 32'(mem_stall), 32'd0);
      check("bad_dreq_valid", 32'(dreq_valid), 32'd0);
      @(posedge clk); #1;
    end
    in_valid = 1'b0; in_op = OP_NONE;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_op = OP_NONE;
    in_addr = '0; in_wdata = '0; flush = 1'b0;
    downstream_stall = 1'b0; dresp_addr_ok = 1'b0;
    dresp_data_ok = 1'b0; dresp_data = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("rst_dreq_valid", 32'(dreq_valid), 32'd0);
    check("rst_strobe", 32'(dreq_strobe), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_rdata", rdata, 32'd0);
    check("rst_stall", 32'(mem_stall), 32'd0);
    @(posedge clk); #1;

    // LW, same-cycle addr_ok/data_ok
    push_req(32'h1000_0004, 2'd2, 4'b0000, 32'h0, 1'b0);
    push_rsp(1'b1, 32'hDEAD_BEEF);
    issue(OP_LW, 32'h1000_0004, 32'h1111_2222, 32'hDEAD_BEEF,
          0, -1, 1'b0, 0, 2, 1);

    // SB at byte 3, addr_ok delayed 3 cycles
    push_req(32'h2000_0003, 2'd0, 4'b1000, 32'hA5A5_A5A5, 1'b1);
    push_rsp(1'b0, 32'h0);
    issue(OP_SB, 32'h2000_0003, 32'h0000_00A5, 32'h0,
          3, -1, 1'b0, 0, 5, 1);

    // LB / LBU on lane 2 with split response
    push_req(32'h3000_0002, 2'd0, 4'b0000, 32'h0, 1'b0);
    push_rsp(1'b1, 32'hFFFF_FF80);
    issue(OP_LB, 32'h3000_0002, 32'h0, 32'h0080_0000,
          1, 1, 1'b0, 0, 5, 1);
    push_req(32'h3000_0002, 2'd0, 4'b0000, 32'h0, 1'b0);
    push_rsp(1'b1, 32'h0000_0080);
    issue(OP_LBU, 32'h3000_0002, 32'h0, 32'h0080_0000,
          0, 0, 1'b0, 0, 3, 1);

    // LH upper half, LHU lower half
    push_req(32'h3000_0002, 2'd1, 4'b0000, 32'h0, 1'b0);
    push_rsp(1'b1, 32'hFFFF_8001);
    issue(OP_LH, 32'h3000_0002, 32'h0, 32'h8001_0000,
          0, -1, 1'b0, 0, 2, 1);
    push_req(32'h3000_0000, 2'd1, 4'b0000, 32'h0, 1'b0);
    push_rsp(1'b1, 32'h0000_F00D);
    issue(OP_LHU, 32'h3000_0000, 32'h0, 32'h1234_F00D,
          2, -1, 1'b0, 0, 4, 1);

    // SH upper half, SW
    push_req(32'h4000_0002, 2'd1, 4'b1100, 32'hBEEF_BEEF, 1'b1);
    push_rsp(1'b0, 32'h0);
    issue(OP_SH, 32'h4000_0002, 32'h0000_BEEF, 32'h0,
          0, -1, 1'b0, 0, 2, 1);
    push_req(32'h4000_0008, 2'd2, 4'b1111, 32'hCAFE_F00D, 1'b1);
    push_rsp(1'b0, 32'h0);
    issue(OP_SW, 32'h4000_0008, 32'hCAFE_F00D, 32'h0,
          0, 3, 1'b0, 0, 6, 1);

    // misaligned ops never reach the bus
    bad(OP_LH,  32'h5000_0001);
    bad(OP_LW,  32'h5000_0002);
    bad(OP_SH,  32'h5000_0003);
    bad(OP_LHU, 32'h5000_0001);

    // NONE passes through
    in_valid = 1'b1; in_op = OP_NONE; in_addr = 32'h5000_0000;
    @(negedge clk);
    check("none_stall", 32'(mem_stall), 32'd0);
    check("none_misalign", 32'(misalign), 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    check("none_dreq_valid", 32'(dreq_valid), 32'd0);
    @(posedge clk); #1;
    in_valid = 1'b0;

    // flush in RESP: no done, stall held to data_ok
    push_req(32'h6000_0000, 2'd2, 4'b0000, 32'h0, 1'b0);
    issue(OP_LW, 32'h6000_0000, 32'h0, 32'h5555_AAAA,
          0, 2, 1'b1, 0, 5, 0);

    // downstream stall holds done/rdata
    push_req(32'h7000_0000, 2'd2, 4'b0000, 32'h0, 1'b0);
    push_rsp(1'b1, 32'h0BAD_F00D);
    issue(OP_LW, 32'h7000_0000, 32'h0, 32'h0BAD_F00D,
          0, -1, 1'b0, 4, 2, 5);

    // reset while in REQ
    push_req(32'h8000_0000, 2'd2, 4'b1111, 32'h1234_5678, 1'b1);
    in_valid = 1'b1; in_op = OP_SW;
    in_addr = 32'h8000_0000; in_wdata = 32'h1234_5678;
    @(negedge clk);
    @(posedge clk); #1;
    @(negedge clk);
    check("req_before_rst", 32'(dreq_valid), 32'd1);
    @(posedge clk); #1;
    reset = 1'b1; in_valid = 1'b0; in_op = OP_NONE;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("mid_rst_dreq_valid", 32'(dreq_valid), 32'd0);
    check("mid_rst_strobe", 32'(dreq_strobe), 32'd0);
    check("mid_rst_done", 32'(done), 32'd0);
    check("mid_rst_rdata", rdata, 32'd0);
    check("mid_rst_stall", 32'(mem_stall), 32'd0);
    if (req_q.size() > 0) void'(req_q.pop_front());
    @(posedge clk); #1;

    check("req_q_empty", req_q.size(), 32'd0);
    check("rsp_q_empty", rsp_q.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
